// File: rtl/fir_par_pkg.sv
// Shared helpers for the L-parallel FIR: width derivation and output clamp.
// The clamp is only referenced when FIR_PAR_SAT_EN is defined.
package fir_par_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Full-precision accumulator: one product width plus log2 of the term count
  function automatic int acc_w(input int dw, input int cw, input int ntap);
    return dw + cw + clog2(ntap);
  endfunction

  // Clamp v to the signed range of a w-bit word
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_par_lane.sv
// One output lane of fir_par: NTAP products registered (stage 2), then the
// adder tree, Q-format shift and DW-bit reduction registered (stage 3).
// Macro FIR_PAR_SAT_EN selects saturation instead of wrap on the reduction.
// The accumulator is widened to 64 bits for the clamp, so ACC_W must be <= 64.
module fir_par_lane import fir_par_pkg::*; #(
  parameter int NTAP  = 8,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_prod,
  input  logic                 en_out,
  input  logic [NTAP*DW-1:0]   x_taps,
  input  logic [NTAP*CW-1:0]   coefs,
  output logic [DW-1:0]        y
);

  localparam int PROD_W = prod_w(DW, CW);
  localparam int ACC_W  = acc_w(DW, CW, NTAP);

  logic signed [PROD_W-1:0] prod [NTAP];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic [DW-1:0]            y_next;

  // Stage 2 products and stage 3 output; y holds while no valid block arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) prod[i] <= '0;
      y <= '0;
    end else begin
      if (en_prod) begin
        for (int i = 0; i < NTAP; i++)
          prod[i] <= PROD_W'(signed'(x_taps[i*DW +: DW])) *
                     PROD_W'(signed'(coefs[i*CW +: CW]));
      end
      if (en_out) y <= y_next;
    end
  end

  // Adder tree, arithmetic scaling and reduction to the output width
  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAP; i++) acc = acc + ACC_W'(prod[i]);
    acc_sh = acc >>> SHIFT;
`ifdef FIR_PAR_SAT_EN
    y_next = DW'(saturate(64'(acc_sh), DW));
`else
    y_next = DW'(acc_sh);
`endif
  end

endmodule

// File: rtl/fir_par.sv
// L-parallel direct-form FIR: PAR samples in and PAR outputs out per clock,
// 3-cycle latency, runtime-writable coefficients. Optional macro
// FIR_PAR_SAT_EN makes each lane saturate rather than wrap. Needs NTAP >= 2.
module fir_par import fir_par_pkg::*; #(
  parameter int PAR   = 3,
  parameter int NTAP  = 8,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PAR*DW-1:0]        x_in,
  input  logic                     coef_we,
  input  logic [clog2(NTAP)-1:0]   coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     out_valid,
  output logic [PAR*DW-1:0]        y_out
);

  localparam int DLY = NTAP - 1;
  localparam int WIN = NTAP + PAR - 1;

  // ext/win index 0 is the newest sample (last lane of the current block)
  logic signed [DW-1:0] dly    [DLY];
  logic signed [DW-1:0] ext    [WIN];
  logic signed [DW-1:0] win_s1 [WIN];
  logic [NTAP*CW-1:0]   h_reg;
  logic [NTAP*CW-1:0]   h_s1;
  logic                 v_s1, v_s2, v_s3;
  logic [NTAP*DW-1:0]   lane_x [PAR];

  // Current block followed by the stored history, newest first
  always_comb begin
    for (int e = 0; e < PAR; e++) ext[e] = x_in[(PAR-1-e)*DW +: DW];
    for (int d = 0; d < DLY; d++) ext[PAR+d] = dly[d];
  end

  // Coefficient file, delay line, stage-1 snapshot and valid pipeline.
  // h_s1 captures the pre-write coefficients, so a write coincident with a
  // valid block only affects blocks arriving on later edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DLY; d++) dly[d] <= '0;
      for (int e = 0; e < WIN; e++) win_s1[e] <= '0;
      h_reg <= '0;
      h_s1  <= '0;
      v_s1  <= 1'b0;
      v_s2  <= 1'b0;
      v_s3  <= 1'b0;
    end else begin
      if (coef_we && (32'(coef_addr) < NTAP))
        h_reg[int'(coef_addr)*CW +: CW] <= coef_data;
      if (in_valid) begin
        for (int d = 0; d < DLY; d++) dly[d] <= ext[d];
        for (int e = 0; e < WIN; e++) win_s1[e] <= ext[e];
        h_s1 <= h_reg;
      end
      v_s1 <= in_valid;
      v_s2 <= v_s1;
      v_s3 <= v_s2;
    end
  end

  // Lane j, tap i sees x(PAR*k + j - i)
  always_comb begin
    for (int j = 0; j < PAR; j++) begin
      lane_x[j] = '0;
      for (int i = 0; i < NTAP; i++) lane_x[j][i*DW +: DW] = win_s1[PAR-1-j+i];
    end
  end

  for (genvar j = 0; j < PAR; j++) begin : g_lane
    fir_par_lane #(
      .NTAP  (NTAP),
      .DW    (DW),
      .CW    (CW),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_prod (v_s1),
      .en_out  (v_s2),
      .x_taps  (lane_x[j]),
      .coefs   (h_s1),
      .y       (y_out[j*DW +: DW])
    );
  end

  assign out_valid = v_s3;

endmodule

// File: tb/tb_fir_par.sv
// Self-checking bench for fir_par: two instances (SHIFT=0 and SHIFT=15) share
// stimulus and are compared against a sample-history convolution model.
module tb_fir_par;

  localparam int PAR  = 3;
  localparam int NTAP = 8;
  localparam int DW   = 16;
  localparam int CW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, coef_we;
  logic [2:0]    coef_addr;
  logic [15:0]   coef_data;
  logic [47:0]   x_in;
  logic          ov0, ov15;
  logic [47:0]   y0, y15;

  fir_par #(.PAR(PAR), .NTAP(NTAP), .DW(DW), .CW(CW), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(ov0), .y_out(y0));

  fir_par #(.PAR(PAR), .NTAP(NTAP), .DW(DW), .CW(CW), .SHIFT(15)) dut15 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(ov15), .y_out(y15));

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint h_m [NTAP];
  longint hist [$];
  bit     pv [3];
  longint pacc [3][PAR];
  bit     exp_ov;
  longint exp_acc [PAR];
  longint xb [PAR];
  logic [15:0] cap0 [$];
  logic [15:0] cap15 [$];

  function automatic logic [15:0] reduce(input longint acc, input int s);
    longint v;
    v = acc >>> s;
`ifdef FIR_PAR_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  // Drive one cycle, advance the model across the edge, capture valid outputs
  task automatic cycle(input bit r, input bit v, input bit we, input int addr, input longint data);
    longint acc;
    int n;
    rst = r; in_valid = v; coef_we = we;
    coef_addr = 3'(addr); coef_data = 16'(data);
    for (int j = 0; j < PAR; j++) x_in[j*DW +: DW] = 16'(xb[j]);
    @(posedge clk);
    if (r) begin
      hist.delete();
      for (int i = 0; i < NTAP; i++) h_m[i] = 0;
      for (int s = 0; s < 3; s++) begin
        pv[s] = 0;
        for (int j = 0; j < PAR; j++) pacc[s][j] = 0;
      end
      exp_ov = 0;
      for (int j = 0; j < PAR; j++) exp_acc[j] = 0;
    end else begin
      pv[2] = pv[1]; pv[1] = pv[0]; pv[0] = v;
      pacc[2] = pacc[1]; pacc[1] = pacc[0];
      if (v) begin
        for (int j = 0; j < PAR; j++) hist.push_back(xb[j]);
        for (int j = 0; j < PAR; j++) begin
          n = hist.size() - PAR + j;
          acc = 0;
          for (int i = 0; i < NTAP; i++)
            if (n - i >= 0) acc += h_m[i] * hist[n-i];
          pacc[0][j] = acc;
        end
      end
      exp_ov = pv[2];
      if (pv[2]) exp_acc = pacc[2];
      if (we && addr < NTAP) h_m[addr] = data;
    end
    @(negedge clk);
    if (ov0)  for (int j = 0; j < PAR; j++) cap0.push_back(y0[j*DW +: DW]);
    if (ov15) for (int j = 0; j < PAR; j++) cap15.push_back(y15[j*DW +: DW]);
  endtask

  task automatic test_reset();
    string tag = "reset";
    xb = '{0, 0, 0};
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (ov0 !== 1'b0 || ov15 !== 1'b0) begin
      errors++; $display("FAIL %s out_valid: got %b/%b want 0", tag, ov0, ov15);
    end
    checks++;
    if (y0 !== 48'h0 || y15 !== 48'h0) begin
      errors++; $display("FAIL %s y_out: got %h/%h want 0", tag, y0, y15);
    end
    // coefficient write while rst=1 must be dropped
    cycle(1, 0, 1, 0, 100);
    xb = '{1, 0, 0};
    cycle(0, 1, 0, 0, 0);
    xb = '{0, 0, 0};
    for (int t = 0; t < 4; t++) begin
      cycle(0, 0, 0, 0, 0);
      for (int j = 0; j < PAR; j++) begin
        checks += 2;
        if (y0[j*DW +: DW] !== reduce(exp_acc[j], 0)) begin
          errors++; $display("FAIL %s y0 lane %0d: got %h want %h", tag, j, y0[j*DW +: DW], reduce(exp_acc[j], 0));
        end
        if (y15[j*DW +: DW] !== reduce(exp_acc[j], 15)) begin
          errors++; $display("FAIL %s y15 lane %0d: got %h want %h", tag, j, y15[j*DW +: DW], reduce(exp_acc[j], 15));
        end
      end
      checks++;
      if (ov0 !== exp_ov || ov15 !== exp_ov) begin
        errors++; $display("FAIL %s out_valid: got %b/%b want %b", tag, ov0, ov15, exp_ov);
      end
    end
  endtask

  // Impulse with an in_valid pattern; all-ones pattern is the gap-free case
  task automatic run_impulse(input string tag, input bit pat [], input bit chk_lat);
    int first_ov = -1;
    int nvalid = 0;
    logic [15:0] want [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
    cycle(1, 0, 0, 0, 0);
    cap0.delete(); cap15.delete();
    xb = '{0, 0, 0};
    for (int i = 0; i < NTAP; i++) cycle(0, 0, 1, i, i + 1);
    for (int t = 0; t < pat.size() + 4; t++) begin
      bit v;
      v = (t < pat.size()) ? pat[t] : 1'b0;
      xb[0] = (v && nvalid == 0) ? 1 : 0;
      if (v) nvalid++;
      cycle(0, v, 0, 0, 0);
      if (ov0 && first_ov < 0) first_ov = t;
      for (int j = 0; j < PAR; j++) begin
        checks += 2;
        if (y0[j*DW +: DW] !== reduce(exp_acc[j], 0)) begin
          errors++; $display("FAIL %s y0 lane %0d: got %h want %h", tag, j, y0[j*DW +: DW], reduce(exp_acc[j], 0));
        end
        if (y15[j*DW +: DW] !== reduce(exp_acc[j], 15)) begin
          errors++; $display("FAIL %s y15 lane %0d: got %h want %h", tag, j, y15[j*DW +: DW], reduce(exp_acc[j], 15));
        end
      end
      checks++;
      if (ov0 !== exp_ov || ov15 !== exp_ov) begin
        errors++; $display("FAIL %s out_valid t=%0d: got %b/%b want %b", tag, t, ov0, ov15, exp_ov);
      end
    end
    if (chk_lat) begin
      checks++;
      if (first_ov != 2) begin
        errors++; $display("FAIL %s latency: first out_valid after cycle %0d want 2", tag, first_ov);
      end
    end
    checks++;
    if (cap0.size() != 12) begin
      errors++; $display("FAIL %s output count: got %0d want 12", tag, cap0.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (cap0[k] !== want[k]) begin
          errors++; $display("FAIL %s y(%0d): got %0d want %0d", tag, k, cap0[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_impulse();
    bit pat [] = '{1, 1, 1, 1};
    run_impulse("impulse", pat, 1'b1);
  endtask

  task automatic test_bubbles();
    bit pat [] = '{1, 0, 0, 1, 1, 0, 1};
    run_impulse("bubbles", pat, 1'b1);
  endtask

  task automatic test_step();
    string tag = "step";
    cycle(1, 0, 0, 0, 0);
    cap0.delete(); cap15.delete();
    xb = '{0, 0, 0};
    for (int i = 0; i < NTAP; i++) cycle(0, 0, 1, i, 4096);
    xb = '{16384, 16384, 16384};
    for (int t = 0; t < 8; t++) begin
      cycle(0, t < 4, 0, 0, 0);
      for (int j = 0; j < PAR; j++) begin
        checks += 2;
        if (y0[j*DW +: DW] !== reduce(exp_acc[j], 0)) begin
          errors++; $display("FAIL %s y0 lane %0d: got %h want %h", tag, j, y0[j*DW +: DW], reduce(exp_acc[j], 0));
        end
        if (y15[j*DW +: DW] !== reduce(exp_acc[j], 15)) begin
          errors++; $display("FAIL %s y15 lane %0d: got %h want %h", tag, j, y15[j*DW +: DW], reduce(exp_acc[j], 15));
        end
      end
      checks++;
      if (ov0 !== exp_ov || ov15 !== exp_ov) begin
        errors++; $display("FAIL %s out_valid: got %b/%b want %b", tag, ov0, ov15, exp_ov);
      end
    end
    checks++;
    if (cap15.size() != 12) begin
      errors++; $display("FAIL %s output count: got %0d want 12", tag, cap15.size());
    end else begin
      for (int n = 0; n < 12; n++) begin
        checks++;
        if (cap15[n] !== 16'(2048 * ((n + 1 < 8) ? n + 1 : 8))) begin
          errors++; $display("FAIL %s y(%0d): got %0d want %0d", tag, n, cap15[n], 2048 * ((n + 1 < 8) ? n + 1 : 8));
        end
      end
    end
  endtask

  task automatic test_reload();
    string tag = "reload";
    cycle(1, 0, 0, 0, 0);
    cap0.delete(); cap15.delete();
    xb = '{0, 0, 0};
    for (int i = 0; i < NTAP; i++) cycle(0, 0, 1, i, 1);
    xb = '{1, 1, 1};
    for (int t = 0; t < 19; t++) begin
      cycle(0, t < 15, t == 10, 0, 5);
      for (int j = 0; j < PAR; j++) begin
        checks++;
        if (y0[j*DW +: DW] !== reduce(exp_acc[j], 0)) begin
          errors++; $display("FAIL %s y0 lane %0d: got %h want %h", tag, j, y0[j*DW +: DW], reduce(exp_acc[j], 0));
        end
      end
      checks++;
      if (ov0 !== exp_ov) begin
        errors++; $display("FAIL %s out_valid: got %b want %b", tag, ov0, exp_ov);
      end
    end
    checks++;
    if (cap0.size() != 45) begin
      errors++; $display("FAIL %s output count: got %0d want 45", tag, cap0.size());
    end else begin
      for (int j = 0; j < PAR; j++) begin
        checks += 2;
        if (cap0[30+j] !== 16'd8) begin
          errors++; $display("FAIL %s block10 lane %0d: got %0d want 8", tag, j, cap0[30+j]);
        end
        if (cap0[33+j] !== 16'd12) begin
          errors++; $display("FAIL %s block11 lane %0d: got %0d want 12", tag, j, cap0[33+j]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    string tag = "overflow";
    logic [15:0] want;
`ifdef FIR_PAR_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'h0008;
`endif
    cycle(1, 0, 0, 0, 0);
    cap0.delete(); cap15.delete();
    xb = '{0, 0, 0};
    for (int i = 0; i < NTAP; i++) cycle(0, 0, 1, i, 32767);
    xb = '{32767, 32767, 32767};
    for (int t = 0; t < 8; t++) cycle(0, t < 5, 0, 0, 0);
    checks++;
    if (cap0.size() != 15) begin
      errors++; $display("FAIL %s output count: got %0d want 15", tag, cap0.size());
    end else begin
      for (int k = 9; k < 15; k++) begin
        checks++;
        if (cap0[k] !== want) begin
          errors++; $display("FAIL %s y(%0d): got %h want %h", tag, k, cap0[k], want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    string tag = "reset_mid";
    logic [15:0] want [3] = '{2048, 4096, 6144};
    cycle(1, 0, 0, 0, 0);
    xb = '{0, 0, 0};
    for (int i = 0; i < NTAP; i++) cycle(0, 0, 1, i, 4096);
    xb = '{16384, 16384, 16384};
    for (int t = 0; t < 4; t++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 7);
    checks++;
    if (ov0 !== 1'b0 || ov15 !== 1'b0) begin
      errors++; $display("FAIL %s out_valid after rst: got %b/%b want 0", tag, ov0, ov15);
    end
    checks++;
    if (y0 !== 48'h0 || y15 !== 48'h0) begin
      errors++; $display("FAIL %s y_out after rst: got %h/%h want 0", tag, y0, y15);
    end
    cap0.delete(); cap15.delete();
    for (int i = 0; i < NTAP; i++) cycle(0, 0, 1, i, 4096);
    for (int t = 0; t < 7; t++) begin
      cycle(0, t < 3, 0, 0, 0);
      for (int j = 0; j < PAR; j++) begin
        checks += 2;
        if (y0[j*DW +: DW] !== reduce(exp_acc[j], 0)) begin
          errors++; $display("FAIL %s y0 lane %0d: got %h want %h", tag, j, y0[j*DW +: DW], reduce(exp_acc[j], 0));
        end
        if (y15[j*DW +: DW] !== reduce(exp_acc[j], 15)) begin
          errors++; $display("FAIL %s y15 lane %0d: got %h want %h", tag, j, y15[j*DW +: DW], reduce(exp_acc[j], 15));
        end
      end
      checks++;
      if (ov0 !== exp_ov || ov15 !== exp_ov) begin
        errors++; $display("FAIL %s out_valid: got %b/%b want %b", tag, ov0, ov15, exp_ov);
      end
    end
    checks++;
    if (cap15.size() != 9) begin
      errors++; $display("FAIL %s output count: got %0d want 9", tag, cap15.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cap15[k] !== want[k]) begin
          errors++; $display("FAIL %s restart y(%0d): got %0d want %0d", tag, k, cap15[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    string tag = "random";
    cycle(1, 0, 0, 0, 0);
    xb = '{0, 0, 0};
    for (int t = 0; t < 304; t++) begin
      bit v, we;
      int addr;
      longint data;
      for (int j = 0; j < PAR; j++) xb[j] = longint'($urandom_range(0, 65535)) - 32768;
      v    = (t < 300) && ($urandom_range(0, 3) != 0);
      we   = (t < 300) && ($urandom_range(0, 2) == 0);
      addr = $urandom_range(0, 7);
      data = longint'($urandom_range(0, 65535)) - 32768;
      cycle(0, v, we, addr, data);
      for (int j = 0; j < PAR; j++) begin
        checks += 2;
        if (y0[j*DW +: DW] !== reduce(exp_acc[j], 0)) begin
          errors++; $display("FAIL %s y0 lane %0d t=%0d: got %h want %h", tag, j, t, y0[j*DW +: DW], reduce(exp_acc[j], 0));
        end
        if (y15[j*DW +: DW] !== reduce(exp_acc[j], 15)) begin
          errors++; $display("FAIL %s y15 lane %0d t=%0d: got %h want %h", tag, j, t, y15[j*DW +: DW], reduce(exp_acc[j], 15));
        end
      end
      checks++;
      if (ov0 !== exp_ov || ov15 !== exp_ov) begin
        errors++; $display("FAIL %s out_valid t=%0d: got %b/%b want %b", tag, t, ov0, ov15, exp_ov);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; x_in = '0;
    xb = '{0, 0, 0};
    test_reset();
    test_impulse();
    test_bubbles();
    test_step();
    test_reload();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
